// File: rtl/grather_less_if.sv
// Operand/result bundle for the registered magnitude comparator.
// The master drives operands and mode, while the slave (comparator) returns the registered flags.
interface grather_less_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic             in_valid;
  logic             c;
  logic             gt;
  logic             lt;
  logic             eq;
  logic             out_valid;

  modport master (
    output a, b, mode, in_valid,
    input  c, gt, lt, eq, out_valid
  );

  modport slave (
    input  a, b, mode, in_valid,
    output c, gt, lt, eq, out_valid
  );
endinterface

// File: rtl/grather_less.sv
// Registered greater/less/equal comparator with one cycle of latency.
// SIGNED selects an unsigned compare or a two's-complement compare.
module grather_less #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b0
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  grather_less_if.slave bus
);

  logic gt_d, lt_d, eq_d, c_d;
  logic gt_q, lt_q, eq_q, c_q, valid_q;

  // lt is derived from gt and eq, so exactly one of the three flags is ever set.
  always_comb begin
    gt_d = 1'b0;
    eq_d = (bus.a == bus.b);
    if (SIGNED) begin
      gt_d = ($signed(bus.a) > $signed(bus.b));
    end else begin
      gt_d = (bus.a > bus.b);
    end
    lt_d = ~gt_d & ~eq_d;
    c_d  = bus.mode ? lt_d : gt_d;
  end

  // Results load only on accepted inputs; idle cycles keep the last result but drop valid.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      c_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        gt_q <= gt_d;
        lt_q <= lt_d;
        eq_q <= eq_d;
        c_q  <= c_d;
      end
    end
  end

  assign bus.c         = c_q;
  assign bus.gt        = gt_q;
  assign bus.lt        = lt_q;
  assign bus.eq        = eq_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_grather_less.sv
// Directed-vector bench for grather_less.
// Unsigned and signed instances share the same stimulus, and each task checks its own results.
module tb_grather_less;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  grather_less_if #(.WIDTH(32)) ubus ();
  grather_less_if #(.WIDTH(32)) sbus ();

  grather_less #(.WIDTH(32), .SIGNED(1'b0)) dut_u (
    .clk_i(clk), .reset_ni(reset_n), .bus(ubus)
  );
  grather_less #(.WIDTH(32), .SIGNED(1'b1)) dut_s (
    .clk_i(clk), .reset_ni(reset_n), .bus(sbus)
  );

  always #5 clk = ~clk;

  // Flags packed as {c, gt, lt, eq, out_valid}.
  function automatic logic [4:0] uflags();
    return {ubus.c, ubus.gt, ubus.lt, ubus.eq, ubus.out_valid};
  endfunction

  function automatic logic [4:0] sflags();
    return {sbus.c, sbus.gt, sbus.lt, sbus.eq, sbus.out_valid};
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic mode, input logic valid);
    ubus.a = a; ubus.b = b; ubus.mode = mode; ubus.in_valid = valid;
    sbus.a = a; sbus.b = b; sbus.mode = mode; sbus.in_valid = valid;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    #12;
    checks++;
    if (uflags() !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL reset_u: got %b expected %b", uflags(), 5'b00000);
    end
    checks++;
    if (sflags() !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL reset_s: got %b expected %b", sflags(), 5'b00000);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    drive(32'd10, 32'd3, 1'b0, 1'b1);
    step();
    checks++;
    if (uflags() !== 5'b11001) begin
      errors++;
      $display("[TB] FAIL basic_gt_u: got %b expected %b", uflags(), 5'b11001);
    end
    checks++;
    if (sflags() !== 5'b11001) begin
      errors++;
      $display("[TB] FAIL basic_gt_s: got %b expected %b", sflags(), 5'b11001);
    end
  endtask

  task automatic test_extremes();
    drive(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    step();
    checks++;
    if (uflags() !== 5'b10101) begin
      errors++;
      $display("[TB] FAIL zero_vs_ones_u: got %b expected %b", uflags(), 5'b10101);
    end
    checks++;
    if (sflags() !== 5'b01001) begin
      errors++;
      $display("[TB] FAIL zero_vs_ones_s: got %b expected %b", sflags(), 5'b01001);
    end
    drive(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1);
    step();
    checks++;
    if (uflags() !== 5'b01001) begin
      errors++;
      $display("[TB] FAIL minneg_vs_maxpos_u: got %b expected %b", uflags(), 5'b01001);
    end
    checks++;
    if (sflags() !== 5'b10101) begin
      errors++;
      $display("[TB] FAIL minneg_vs_maxpos_s: got %b expected %b", sflags(), 5'b10101);
    end
  endtask

  task automatic test_equal();
    for (int m = 0; m < 2; m++) begin
      drive(32'h1234_5678, 32'h1234_5678, m[0], 1'b1);
      step();
      checks++;
      if (uflags() !== 5'b00011) begin
        errors++;
        $display("[TB] FAIL equal_u mode=%0d: got %b expected %b", m, uflags(), 5'b00011);
      end
      checks++;
      if (sflags() !== 5'b00011) begin
        errors++;
        $display("[TB] FAIL equal_s mode=%0d: got %b expected %b", m, sflags(), 5'b00011);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] av [5];
    logic [31:0] bv [5];
    logic        expU [5];
    logic        expS [5];
    av   = '{32'd1, 32'd5, 32'd9, 32'h8000_0000, 32'd7};
    bv   = '{32'd2, 32'd5, 32'd0, 32'd1, 32'd8};
    expU = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    expS = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(av[i], bv[i], 1'b0, 1'b1);
      step();
      checks++;
      if ({ubus.c, ubus.out_valid} !== {expU[i], 1'b1}) begin
        errors++;
        $display("[TB] FAIL b2b_u[%0d]: got c=%b ov=%b expected c=%b ov=1",
                 i, ubus.c, ubus.out_valid, expU[i]);
      end
      checks++;
      if ({sbus.c, sbus.out_valid} !== {expS[i], 1'b1}) begin
        errors++;
        $display("[TB] FAIL b2b_s[%0d]: got c=%b ov=%b expected c=%b ov=1",
                 i, sbus.c, sbus.out_valid, expS[i]);
      end
    end
  endtask

  task automatic test_hold();
    drive(32'd3, 32'd1, 1'b0, 1'b1);
    step();
    checks++;
    if (uflags() !== 5'b11001) begin
      errors++;
      $display("[TB] FAIL hold_accept: got %b expected %b", uflags(), 5'b11001);
    end
    // Idle operands deliberately disagree with the held result.
    drive(32'd0, 32'd5, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (uflags() !== 5'b11000) begin
        errors++;
        $display("[TB] FAIL hold_idle_u[%0d]: got %b expected %b", i, uflags(), 5'b11000);
      end
      checks++;
      if (sflags() !== 5'b11000) begin
        errors++;
        $display("[TB] FAIL hold_idle_s[%0d]: got %b expected %b", i, sflags(), 5'b11000);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(32'd9, 32'd0, 1'b0, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (uflags() !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL async_reset_u: got %b expected %b", uflags(), 5'b00000);
    end
    checks++;
    if (sflags() !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL async_reset_s: got %b expected %b", sflags(), 5'b00000);
    end
    step();
    checks++;
    if (uflags() !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL reset_held_edge: got %b expected %b", uflags(), 5'b00000);
    end
    drive(32'd9, 32'd0, 1'b0, 1'b0);
    reset_n = 1'b1;
    step();
    checks++;
    if (uflags() !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL release_no_pulse: got %b expected %b", uflags(), 5'b00000);
    end
  endtask

  task automatic test_after_reset();
    drive(32'd9, 32'd0, 1'b0, 1'b1);
    step();
    checks++;
    if (uflags() !== 5'b11001) begin
      errors++;
      $display("[TB] FAIL first_after_reset_u: got %b expected %b", uflags(), 5'b11001);
    end
    checks++;
    if (sflags() !== 5'b11001) begin
      errors++;
      $display("[TB] FAIL first_after_reset_s: got %b expected %b", sflags(), 5'b11001);
    end
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_equal();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_after_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/grather_less.md
GRATHER_LESS -- requirements
Module: grather_less

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits; legal range 1..64.
REQ-002 Parameter: SIGNED, default 0; 0 = unsigned compare, 1 = two's-complement compare.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 a  input  WIDTH  first operand.
REQ-006 b  input  WIDTH  second operand.
REQ-007 mode  input  1  0 = greater test (a > b), 1 = less test (a < b).
REQ-008 in_valid  input  1  operands and mode are sampled this cycle when 1.
REQ-009 c  output  1  registered compare result for the selected mode.
REQ-010 gt  output  1  registered flag, a > b.
REQ-011 lt  output  1  registered flag, a < b.
REQ-012 eq  output  1  registered flag, a == b.
REQ-013 out_valid  output  1  registered; 1 for exactly one cycle per accepted input.

Function
REQ-014 On a rising clk edge with in_valid=1, the block SHALL compute gt/lt/eq from a and b.
- The compare is unsigned when SIGNED=0.
- The compare is two's-complement when SIGNED=1.
REQ-015 c SHALL equal gt when the sampled mode=0, and lt when the sampled mode=1.
REQ-016 Latency SHALL be exactly one cycle: results and out_valid=1 appear after the edge that samples in_valid=1.
REQ-017 On an edge with in_valid=0, out_valid SHALL go to 0, and c/gt/lt/eq SHALL hold their previous values.
REQ-018 Exactly one of gt, lt, eq SHALL be 1 whenever out_valid=1.
REQ-019 Back-to-back in_valid=1 cycles SHALL each produce one result on consecutive cycles, with no bubbles or stalls.
REQ-020 Equal operands SHALL give eq=1, gt=0, lt=0 and c=0 in either mode.
REQ-021 Extremes SHALL compare correctly:
- all-zeros vs all-ones, unsigned: lt=1.
- most-negative vs most-positive, signed: lt=1.
REQ-022 The result SHALL depend only on the sampled a, b and mode.
- No X propagation from unsampled cycles.
- No combinational path from inputs to outputs.

Reset
REQ-023 While reset=0, c, gt, lt, eq and out_valid SHALL be 0, regardless of clk.
- Assertion takes effect immediately (asynchronously).
REQ-024 Reset asserted mid-operation SHALL discard any in-flight result; no out_valid pulse appears for it after release.
REQ-025 After reset deasserts, the first rising edge with in_valid=1 SHALL be accepted normally.

Verification
REQ-026 WIDTH=32, SIGNED=0, mode=0, a=10, b=3, in_valid=1 -> next cycle: c=1, gt=1, lt=0, eq=0, out_valid=1.
REQ-027 WIDTH=32, SIGNED=0, mode=1, a=0x00000000, b=0xFFFFFFFF -> c=1, lt=1. Same operands with SIGNED=1 -> c=0, gt=1.
REQ-028 a=b=0x12345678 in both modes -> c=0, eq=1, gt=0, lt=0.
REQ-029 Five back-to-back pairs (a,b) = (1,2), (5,5), (9,0), (0x80000000,1), (7,8), mode=0, SIGNED=0 -> c = 0, 0, 1, 1, 0 on five consecutive cycles, out_valid held at 1.
REQ-030 Drive reset=0 while in_valid=1 with a=9, b=0 -> all outputs 0 immediately. Release reset with in_valid=0 -> out_valid stays 0.
REQ-031 in_valid=1 for one cycle (a=3, b=1, mode=0), then in_valid=0 for 3 cycles -> out_valid is a single one-cycle pulse, and c stays 1 throughout.
